online_stream_driver: RTL and testbench

- Synthesizable, parametrised multi-channel source of MSD-first signed-digit operand streams for the online arithmetic units (Multiplier_hd and its successors).
- Replaces file-driven stimulus: operands are loaded in parallel, buffered per channel, then serialised one 2-bit digit per handshake on valid/ready.
- Optional LFSR-driven valid-stall injection exercises consumer backpressure and bubble handling.

---
 rtl/online_stream_driver.sv | 222 ++++++++++++++++++++++
 tb/tb_online_stream_driver.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/online_stream_driver.sv
// rtl/online_stream_driver.sv - multi-channel MSD-first signed-digit operand stream source
// Parallel operands are buffered per channel and serialised one 2-bit digit per valid/ready handshake.

module osd_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             empty,
    output logic             full
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_n;
    logic             push_ok;
    logic             pop_ok;

    // A push to a full FIFO is dropped even when the same edge pops it.
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];

    always_comb begin
        count_n = count;
        if (push_ok && !pop_ok) begin
            count_n = count + CNT_W'(1);
        end else if (!push_ok && pop_ok) begin
            count_n = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_n;
            full  <= (count_n == CNT_W'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end
endmodule

module osd_lfsr #(
    parameter logic [15:0] SEED  = 16'hACE1,
    parameter int          OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [OUT_W-1:0] tap
);
    logic [15:0] state;
    logic        fb;

    // Fibonacci form, taps 16,14,13,11: maximal length, so every nibble value recurs.
    assign fb  = state[15] ^ state[13] ^ state[12] ^ state[10];
    assign tap = state[OUT_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED;
        end else begin
            state <= {state[14:0], fb};
        end
    end
endmodule

module online_stream_driver #(
    parameter int          NUM_CH     = 2,
    parameter int          DIGITS     = 16,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  asyn_reset,
    input  logic                  op_wr_en,
    input  logic [1:0]            op_wr_ch,
    input  logic [2*DIGITS-1:0]   op_wr_data,
    output logic [NUM_CH-1:0]     op_full,
    input  logic [3:0]            stall_thresh,
    output logic [2*NUM_CH-1:0]   dig_data,
    output logic [NUM_CH-1:0]     dig_vld,
    input  logic [NUM_CH-1:0]     dig_rdy,
    output logic [NUM_CH-1:0]     dig_last,
    output logic [NUM_CH-1:0]     busy,
    output logic [NUM_CH-1:0]     enc_err
);
    localparam int               OP_W    = 2 * DIGITS;
    localparam int               IDX_W   = $clog2(DIGITS);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DIGITS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    logic [4*NUM_CH-1:0] lfsr_tap;

    osd_lfsr #(
        .SEED  (LFSR_SEED),
        .OUT_W (4 * NUM_CH)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (asyn_reset),
        .tap   (lfsr_tap)
    );

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        state_t            state;
        logic [OP_W-1:0]   sr;
        logic [IDX_W-1:0]  idx;
        logic              vld;
        logic              last;
        logic              err;
        logic              push;
        logic              pop;
        logic              empty;
        logic              full;
        logic              stall;
        logic              can_load;
        logic              hs;
        logic [OP_W-1:0]   pop_data;

        assign push     = op_wr_en & (int'(op_wr_ch) == c);
        assign stall    = (lfsr_tap[4*c +: 4] < stall_thresh);
        assign can_load = ~empty & ~stall;
        assign hs       = vld & dig_rdy[c];
        // Stall only gates raising valid: a load from IDLE or the reload after the LSD.
        assign pop      = can_load & (~vld | (hs & (idx == '0)));

        osd_fifo #(
            .WIDTH (OP_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (asyn_reset),
            .push      (push),
            .push_data (op_wr_data),
            .pop       (pop),
            .pop_data  (pop_data),
            .empty     (empty),
            .full      (full)
        );

        // The current digit always sits in the top two bits of the shift register.
        always_ff @(posedge clk or negedge asyn_reset) begin
            if (!asyn_reset) begin
                state <= IDLE;
                sr    <= '0;
                idx   <= '0;
                vld   <= 1'b0;
                last  <= 1'b0;
                err   <= 1'b0;
            end else begin
                if (vld && sr[OP_W-1 -: 2] == 2'b11) begin
                    err <= 1'b1;
                end
                case (state)
                    IDLE: begin
                        if (can_load) begin
                            sr    <= pop_data;
                            idx   <= IDX_MAX;
                            vld   <= 1'b1;
                            last  <= 1'b0;
                            state <= EMIT;
                        end
                    end
                    EMIT: begin
                        if (dig_rdy[c]) begin
                            if (idx != '0) begin
                                sr   <= {sr[OP_W-3:0], 2'b00};
                                idx  <= idx - IDX_W'(1);
                                last <= (idx == IDX_W'(1));
                            end else if (can_load) begin
                                sr   <= pop_data;
                                idx  <= IDX_MAX;
                                last <= 1'b0;
                            end else begin
                                sr    <= '0;
                                vld   <= 1'b0;
                                last  <= 1'b0;
                                state <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end

        assign dig_data[2*c +: 2] = sr[OP_W-1 -: 2];
        assign dig_vld[c]         = vld;
        assign dig_last[c]        = last;
        assign busy[c]            = vld | ~empty;
        assign enc_err[c]         = err;
        assign op_full[c]         = full;
    end
endmodule

// File: tb/tb_online_stream_driver.sv
// tb/tb_online_stream_driver.sv - scoreboard bench for online_stream_driver
// Expected digits are queued per channel when operands are written and compared on each handshake.

module tb_online_stream_driver;
    logic        clk;
    logic        asyn_reset;
    logic        op_wr_en;
    logic [1:0]  op_wr_ch;
    logic [31:0] op_wr_data;
    logic [1:0]  op_full;
    logic [3:0]  stall_thresh;
    logic [3:0]  dig_data;
    logic [1:0]  dig_vld;
    logic [1:0]  dig_rdy;
    logic [1:0]  dig_last;
    logic [1:0]  busy;
    logic [1:0]  enc_err;

    online_stream_driver #(
        .NUM_CH     (2),
        .DIGITS     (16),
        .FIFO_DEPTH (4),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk          (clk),
        .asyn_reset   (asyn_reset),
        .op_wr_en     (op_wr_en),
        .op_wr_ch     (op_wr_ch),
        .op_wr_data   (op_wr_data),
        .op_full      (op_full),
        .stall_thresh (stall_thresh),
        .dig_data     (dig_data),
        .dig_vld      (dig_vld),
        .dig_rdy      (dig_rdy),
        .dig_last     (dig_last),
        .busy         (busy),
        .enc_err      (enc_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    bit mon_en = 1'b0;

    logic [2:0] q0 [$];
    logic [2:0] q1 [$];
    int         hs_cnt   [2];
    int         first_hs [2];
    int         last_hs  [2];
    int         wait_cnt [2];
    bit         hold     [2];
    logic [1:0] hold_d   [2];
    logic       hold_l   [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sb_size(input int c);
        return (c == 0) ? q0.size() : q1.size();
    endfunction

    task automatic sb_pop(input int c, output logic [2:0] v);
        if (c == 0) v = q0.pop_front();
        else        v = q1.pop_front();
    endtask

    // Digits go out MSD first; the LSD carries the last flag.
    task automatic sb_push(input int c, input logic [31:0] op);
        for (int i = 15; i >= 0; i--) begin
            logic [2:0] e;
            e = {(i == 0), op[2*i +: 2]};
            if (c == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    function automatic logic [31:0] rand_op();
        logic [31:0] v;
        for (int i = 0; i < 16; i++) begin
            case ($urandom_range(0, 2))
                0:       v[2*i +: 2] = 2'b00;
                1:       v[2*i +: 2] = 2'b01;
                default: v[2*i +: 2] = 2'b10;
            endcase
        end
        return v;
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (mon_en) begin
            for (int c = 0; c < 2; c++) begin
                logic [1:0] d;
                logic [2:0] e;
                d = dig_data[2*c +: 2];
                if (hold[c]) begin
                    check("hold_vld", dig_vld[c], 1'b1);
                    check("hold_data", d, hold_d[c]);
                    check("hold_last", dig_last[c], hold_l[c]);
                end
                if (dig_vld[c] && dig_rdy[c]) begin
                    check("sb_has_digit", (sb_size(c) != 0), 1'b1);
                    if (sb_size(c) != 0) begin
                        sb_pop(c, e);
                        check("digit", d, e[1:0]);
                        check("last", dig_last[c], e[2]);
                    end
                    hs_cnt[c]++;
                    if (first_hs[c] < 0) first_hs[c] = cyc;
                    last_hs[c] = cyc;
                end
                if (busy[c] && !dig_vld[c]) wait_cnt[c]++;
                hold[c]   = dig_vld[c] && !dig_rdy[c];
                hold_d[c] = d;
                hold_l[c] = dig_last[c];
            end
        end
    end

    task automatic write_op(input int ch, input logic [31:0] data);
        op_wr_en   = 1'b1;
        op_wr_ch   = 2'(ch);
        op_wr_data = data;
        @(posedge clk);
        #1;
        op_wr_en   = 1'b0;
    endtask

    task automatic drain(input int budget, input bit rand_rdy);
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < budget) begin
            if (rand_rdy) dig_rdy = 2'($urandom_range(0, 3));
            @(posedge clk);
            #1;
            n++;
        end
        dig_rdy = 2'b11;
        check("drain_done", (q0.size() == 0 && q1.size() == 0), 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_marks();
        for (int c = 0; c < 2; c++) begin
            first_hs[c] = -1;
            last_hs[c]  = -1;
            wait_cnt[c] = 0;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] op;
        int          base;

        asyn_reset   = 1'b0;
        op_wr_en     = 1'b0;
        op_wr_ch     = 2'd0;
        op_wr_data   = '0;
        stall_thresh = 4'd0;
        dig_rdy      = 2'b11;
        for (int c = 0; c < 2; c++) begin
            hs_cnt[c] = 0;
            hold[c]   = 1'b0;
            hold_d[c] = 2'b00;
            hold_l[c] = 1'b0;
        end
        clear_marks();
        #2;
        check("rst_vld", dig_vld, 2'b00);
        check("rst_busy", busy, 2'b00);
        check("rst_full", op_full, 2'b00);
        check("rst_enc", enc_err, 2'b00);
        check("rst_data", dig_data, 4'h0);
        check("rst_last", dig_last, 2'b00);
        @(posedge clk);
        #1;
        asyn_reset = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Out-of-range channel write is ignored
        write_op(2, 32'h8888_8888);
        @(posedge clk);
        #1;
        check("bad_ch_busy", busy, 2'b00);

        // Single operand on ch0, pattern +1,-1,0,+1 repeating from the MSD
        for (int k = 0; k < 16; k++) begin
            case (k % 4)
                0:       op[2*(15-k) +: 2] = 2'b10;
                1:       op[2*(15-k) +: 2] = 2'b01;
                2:       op[2*(15-k) +: 2] = 2'b00;
                default: op[2*(15-k) +: 2] = 2'b10;
            endcase
        end
        clear_marks();
        sb_push(0, op);
        write_op(0, op);
        check("lat_vld_t", dig_vld[0], 1'b0);
        @(posedge clk);
        #1;
        check("lat_vld_t1", dig_vld[0], 1'b1);
        check("lat_msd", dig_data[1:0], 2'b10);
        drain(200, 1'b0);
        check("t1_busy_fall", busy[0], 1'b0);
        check("t1_span", last_hs[0] - first_hs[0], 15);

        // Fill ch1 with ready held low: one operand loads, four buffer, sixth dropped
        clear_marks();
        base = hs_cnt[1];
        dig_rdy = 2'b01;
        for (int i = 0; i < 6; i++) begin
            op = rand_op();
            write_op(1, op);
            if (i < 5) sb_push(1, op);
            if (i == 3) check("full_after_4", op_full[1], 1'b0);
            if (i >= 4) check("full_after_5", op_full[1], 1'b1);
        end
        dig_rdy = 2'b11;
        drain(500, 1'b0);
        check("t2_count", hs_cnt[1] - base, 80);
        check("t2_no_bubble", last_hs[1] - first_hs[1], 79);
        check("t2_busy_fall", busy[1], 1'b0);
        check("t2_full_clear", op_full[1], 1'b0);

        // Backpressure 1,0,0,1 mid-operand on ch0
        clear_marks();
        base = hs_cnt[0];
        op = rand_op();
        sb_push(0, op);
        write_op(0, op);
        @(posedge clk);
        #1;
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        dig_rdy[0] = 1'b1;
        @(posedge clk);
        #1;
        dig_rdy[0] = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        dig_rdy[0] = 1'b1;
        drain(200, 1'b0);
        check("t3_count", hs_cnt[0] - base, 16);
        check("t3_span", last_hs[0] - first_hs[0], 17);

        // Heavy stall with random ready, two operands per channel
        clear_marks();
        stall_thresh = 4'd15;
        for (int i = 0; i < 4; i++) begin
            op = rand_op();
            sb_push(i % 2, op);
            write_op(i % 2, op);
        end
        drain(5000, 1'b1);
        check("t4_stall_gaps", (wait_cnt[0] + wait_cnt[1] > 2), 1'b1);
        check("t4_busy_fall", busy, 2'b00);
        stall_thresh = 4'd0;

        // Illegal digit 11 at digit 5 of a ch0 operand
        op = rand_op();
        op[11:10] = 2'b11;
        sb_push(0, op);
        write_op(0, op);
        drain(200, 1'b0);
        check("enc_set", enc_err, 2'b01);
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("enc_sticky", enc_err, 2'b01);

        // Asynchronous reset mid-operand
        dig_rdy = 2'b01;
        for (int i = 0; i < 5; i++) write_op(1, rand_op());
        check("t6_full_before", op_full[1], 1'b1);
        op = rand_op();
        sb_push(0, op);
        write_op(0, op);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #2;
        mon_en = 1'b0;
        asyn_reset = 1'b0;
        #1;
        check("t6_vld_clear", dig_vld, 2'b00);
        check("t6_busy_clear", busy, 2'b00);
        check("t6_full_clear", op_full, 2'b00);
        check("t6_enc_clear", enc_err, 2'b00);
        q0.delete();
        q1.delete();
        @(posedge clk);
        #3;
        asyn_reset = 1'b1;
        dig_rdy = 2'b11;
        for (int c = 0; c < 2; c++) hold[c] = 1'b0;
        base = hs_cnt[0] + hs_cnt[1];
        mon_en = 1'b1;
        repeat (20) begin
            @(posedge clk);
            #1;
        end
        check("t6_idle_vld", dig_vld, 2'b00);
        check("t6_idle_busy", busy, 2'b00);
        check("t6_idle_hs", hs_cnt[0] + hs_cnt[1] - base, 0);
        clear_marks();
        op = rand_op();
        sb_push(1, op);
        write_op(1, op);
        drain(200, 1'b0);
        check("t6_after_span", last_hs[1] - first_hs[1], 15);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
